// File: rtl/frac_tick_pkg.sv
// Shared constants for the fractional tick generator: fixed-point unit,
// smallest legal divisor and the power-on divisor (27 MHz -> 48 kHz).
package frac_tick_pkg;

    localparam int DEF_RESET_DIV = 9000;

    function automatic int one_f(input int frac_w);
        return 1 << frac_w;
    endfunction

    function automatic int min_div_f(input int frac_w);
        return 2 << frac_w;
    endfunction

endpackage

// File: rtl/tick_subdivider.sv
// Counts incoming ticks modulo SUB_N and flags the tick that wraps the count.
// sub_tick is registered so it lines up with the registered tick of the parent.
module tick_subdivider
    import frac_tick_pkg::*;
#(
    parameter int SUB_N = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_in,
    output logic sub_tick
);

    localparam int CW = $clog2(SUB_N);
    localparam logic [CW-1:0] LAST = CW'(SUB_N - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sub_q, sub_d;

    always_comb begin
        cnt_d = cnt_q;
        sub_d = 1'b0;
        if (tick_in) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                sub_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            sub_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sub_q <= sub_d;
        end
    end

    assign sub_tick = sub_q;

endmodule

// File: rtl/frac_tick_gen.sv
// Fractional-N tick generator: a phase accumulator advances by ONE per enabled
// cycle and wraps at the Q(INT_W).(FRAC_W) divisor, giving an average tick period of D.
module frac_tick_gen
    import frac_tick_pkg::*;
#(
    parameter int INT_W     = 16,
    parameter int FRAC_W    = 4,
    parameter int RESET_DIV = DEF_RESET_DIV,
    parameter int SUB_N     = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [INT_W+FRAC_W-1:0] div_in,
    input  logic                    div_load,
    output logic                    tick,
    output logic                    sub_tick,
    output logic                    div_busy,
    output logic                    div_err
);

    localparam int DW = INT_W + FRAC_W;
    localparam int PW = DW + 1;
    localparam logic [PW-1:0] ONE_P = PW'(one_f(FRAC_W));
    localparam logic [PW-1:0] MIN_P = PW'(min_div_f(FRAC_W));

    logic [PW-1:0] p_q, p_d, p_inc;
    logic [DW-1:0] d_q, d_d, pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic          tick_q, err_q, err_d;
    logic          wrap, load_ok;

    // One spare bit keeps p + ONE exact even when D sits near full scale.
    assign p_inc   = p_q + ONE_P;
    assign wrap    = en && (p_inc >= {1'b0, d_q});
    assign load_ok = ({1'b0, div_in} >= MIN_P);

    always_comb begin
        p_d      = p_q;
        d_d      = d_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        err_d    = 1'b0;
        if (en) begin
            p_d = wrap ? (p_inc - {1'b0, d_q}) : p_inc;
            if (wrap && pend_v_q) begin
                d_d      = pend_q;
                pend_v_d = 1'b0;
            end
        end else if (pend_v_q) begin
            // While stopped there is no wrap to wait for: switch now and restart phase.
            d_d      = pend_q;
            p_d      = '0;
            pend_v_d = 1'b0;
        end
        // A load in the same cycle as a wrap waits for the following wrap.
        if (div_load) begin
            if (load_ok) begin
                pend_d   = div_in;
                pend_v_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p_q      <= '0;
            d_q      <= DW'(RESET_DIV);
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tick_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            p_q      <= p_d;
            d_q      <= d_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= wrap;
            err_q    <= err_d;
        end
    end

    tick_subdivider #(.SUB_N(SUB_N)) u_sub (
        .clock    (clock),
        .reset    (reset),
        .tick_in  (wrap),
        .sub_tick (sub_tick)
    );

    assign tick     = tick_q;
    assign div_busy = pend_v_q;
    assign div_err  = err_q;

endmodule

// File: tb/tb_frac_tick_gen.sv
// Directed bench: a cycle table on a small-divisor instance (SUB_N=4, D=32)
// plus long-period sequences on a default-parameter instance.
module tb_frac_tick_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst1 = 1'b1, en1 = 1'b0, ld1 = 1'b0;
    logic [19:0] din1 = '0;
    logic        tick1, sub1, busy1, err1;

    frac_tick_gen u_dut1 (
        .clock(clk), .reset(rst1), .en(en1), .div_in(din1), .div_load(ld1),
        .tick(tick1), .sub_tick(sub1), .div_busy(busy1), .div_err(err1)
    );

    // small instance for the table
    logic        rst2 = 1'b1, en2 = 1'b0, ld2 = 1'b0;
    logic [19:0] din2 = '0;
    logic        tick2, sub2, busy2, err2;

    frac_tick_gen #(.RESET_DIV(32), .SUB_N(4)) u_dut2 (
        .clock(clk), .reset(rst2), .en(en2), .div_in(din2), .div_load(ld2),
        .tick(tick2), .sub_tick(sub2), .div_busy(busy2), .div_err(err2)
    );

    typedef struct {
        logic        rst, en, ld;
        logic [19:0] din;
        logic        tick, sub, busy, err;
    } vec_t;

    vec_t vq[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, flg = 0;
    int   ticks[$];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic l, input int d,
                       input logic t, input logic s, input logic b, input logic er);
        vec_t v;
        v.rst = r; v.en = e; v.ld = l; v.din = 20'(d);
        v.tick = t; v.sub = s; v.busy = b; v.err = er;
        vq.push_back(v);
    endtask

    function automatic int tk(input int i);
        return (i < ticks.size()) ? ticks[i] : -1;
    endfunction

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cyc++;
            if (tick1) ticks.push_back(cyc);
            if (sub1 || err1) flg++;
            ld1 = 1'b0;
        end
    endtask

    task automatic reset1(input string nm);
        rst1 = 1'b1; ld1 = 1'b0;
        @(posedge clk); #1;
        chk({nm, " reset outs"}, {28'd0, tick1, sub1, busy1, err1}, 0);
        rst1 = 1'b0; en1 = 1'b1;
        cyc = 0; flg = 0;
        ticks.delete();
    endtask

    initial begin
        // ---- table on the small instance: rst en ld din | tick sub busy err
        add(1,0,0,0,   0,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,1,0,0);   // 4th tick -> sub_tick
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(1,1,1,100, 0,0,0,0);   // reset overrides en/load, restarts sub count
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,1,0,0);
        add(0,1,1,31,  0,0,0,1);   // rejected load
        add(0,1,0,0,   1,0,0,0);
        add(0,1,1,48,  0,0,1,0);   // legal load -> busy
        add(0,1,0,0,   1,0,0,0);   // wrap with old D=32, then D=48
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,1,0,0);   // sub count survived divisor change
        add(0,0,1,32,  0,0,1,0);   // load while stopped
        add(0,0,0,0,   0,0,0,0);   // applied immediately, p cleared
        add(0,1,0,0,   0,0,0,0);
        add(0,1,0,0,   1,0,0,0);

        foreach (vq[i]) begin
            rst2 = vq[i].rst; en2 = vq[i].en; ld2 = vq[i].ld; din2 = vq[i].din;
            @(posedge clk); #1;
            chk($sformatf("vec%0d {tick,sub,busy,err}", i),
                {28'd0, tick2, sub2, busy2, err2},
                {28'd0, vq[i].tick, vq[i].sub, vq[i].busy, vq[i].err});
        end
        rst2 = 1'b1; en2 = 1'b0; ld2 = 1'b0;

        // ---- A: D=9000 free run
        reset1("A");
        run(3000);
        chk("A tick count", ticks.size(), 5);
        chk("A tick0", tk(0), 563);
        chk("A tick1", tk(1), 1125);
        chk("A tick2", tk(2), 1688);
        chk("A tick3", tk(3), 2250);
        chk("A tick4", tk(4), 2813);
        chk("A sub/err seen", flg, 0);

        // ---- B: en low for 100 cycles delays the tick by 100
        reset1("B");
        run(200);
        en1 = 1'b0;
        run(100);
        chk("B ticks while stopped", ticks.size(), 0);
        en1 = 1'b1;
        run(400);
        chk("B tick count", ticks.size(), 1);
        chk("B tick0", tk(0), 663);

        // ---- C: load 2.0 mid-period
        reset1("C");
        run(300);
        ld1 = 1'b1; din1 = 20'd32;
        run(1);
        chk("C busy after load", busy1, 1);
        run(261);
        chk("C busy before wrap", busy1, 1);
        run(1);
        chk("C tick at wrap", tick1, 1);
        chk("C busy cleared", busy1, 0);
        run(6);
        chk("C tick count", ticks.size(), 4);
        chk("C tick0", tk(0), 563);
        chk("C tick1", tk(1), 565);
        chk("C tick2", tk(2), 567);
        chk("C tick3", tk(3), 569);

        // ---- D: illegal load 31
        reset1("D");
        run(99);
        ld1 = 1'b1; din1 = 20'd31;
        run(1);
        chk("D err pulse", err1, 1);
        chk("D busy stays low", busy1, 0);
        run(1);
        chk("D err single cycle", err1, 0);
        run(1024);
        chk("D tick count", ticks.size(), 2);
        chk("D tick0", tk(0), 563);
        chk("D tick1", tk(1), 1125);

        // ---- E: second load overwrites pending
        reset1("E");
        run(99);
        ld1 = 1'b1; din1 = 20'd160;
        run(1);
        run(99);
        ld1 = 1'b1; din1 = 20'd320;
        run(1);
        chk("E busy with pending", busy1, 1);
        run(403);
        chk("E tick count", ticks.size(), 3);
        chk("E tick0", tk(0), 563);
        chk("E tick1", tk(1), 583);
        chk("E tick2", tk(2), 603);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
